// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: cycles each digit position through a dark
// anti-ghosting gap, a one-cycle code fetch, and a lit dwell.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SHOW_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] digit_code,
  output logic [2:0] digit_sel,
  output logic [7:0] anode_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int MAXC  = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] B_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_LAST   = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [2:0]       SEL_LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {BLANK, LOAD, SHOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       sel_nxt;
  logic [7:0]       code, code_nxt;
  logic [7:0]       anode_nxt;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] decode(input logic [7:0] c);
    case (c)
      8'd0:    decode = 7'h40;
      8'd1:    decode = 7'h79;
      8'd2:    decode = 7'h24;
      8'd3:    decode = 7'h30;
      8'd4:    decode = 7'h19;
      8'd5:    decode = 7'h12;
      8'd6:    decode = 7'h02;
      8'd7:    decode = 7'h78;
      8'd8:    decode = 7'h00;
      8'd9:    decode = 7'h10;
      8'hFF:   decode = 7'h7F;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = digit_sel;
    code_nxt  = code;
    if (!en) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == B_LAST) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          code_nxt  = digit_code;
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
        SHOW: begin
          if (cnt == S_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            sel_nxt   = (digit_sel == SEL_LAST) ? 3'd0 : digit_sel + 3'd1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Outputs are computed from the next state so the registered pins line up with the state register.
    anode_nxt = 8'hFF;
    seg_nxt   = 7'h7F;
    if (state_nxt == SHOW) begin
      anode_nxt = ~(8'd1 << sel_nxt);
      seg_nxt   = decode(code_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BLANK;
      cnt       <= '0;
      digit_sel <= 3'd0;
      code      <= 8'hFF;
      anode_n   <= 8'hFF;
      seg_n     <= 7'h7F;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_sel <= sel_nxt;
      code      <= code_nxt;
      anode_n   <= anode_nxt;
      seg_n     <= seg_nxt;
    end
  end

  assign dp_n = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: a per-position period model predicts
// every output each cycle for a 4-digit and a 1-digit instance.
module tb_seg_scan_driver;

  localparam int S  = 4;
  localparam int B  = 2;
  localparam int N  = 4;
  localparam int P  = B + 1 + S;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] digit_code = 8'd3;
  logic [2:0] digit_sel, sel1;
  logic [7:0] anode_n, anode1;
  logic [6:0] seg_n, seg1;
  logic       dp_n, dp1;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [7:0] src [0:7];

  int m_t, m_sel, m1_t, m1_sel;
  logic [7:0] m_code, m1_code;

  seg_scan_driver #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_code(digit_code),
    .digit_sel(digit_sel), .anode_n(anode_n), .seg_n(seg_n), .dp_n(dp_n));

  seg_scan_driver #(.NUM_DIGITS(1), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_code(digit_code),
    .digit_sel(sel1), .anode_n(anode1), .seg_n(seg1), .dp_n(dp1));

  always #5 clk = ~clk;

  // Reference: position within the B+1+S period, the position index, the latched code
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_sel <= 0; m_code <= 8'hFF;
      m1_t <= 0; m1_sel <= 0; m1_code <= 8'hFF;
    end else if (!en) begin
      m_t <= 0; m1_t <= 0;
    end else begin
      if (m_t == B) m_code <= digit_code;
      if (m_t == P - 1) begin m_t <= 0; m_sel <= (m_sel + 1) % N; end
      else m_t <= m_t + 1;
      if (m1_t == B) m1_code <= digit_code;
      if (m1_t == P - 1) begin m1_t <= 0; m1_sel <= (m1_sel + 1) % 1; end
      else m1_t <= m1_t + 1;
    end
  end

  function automatic logic [6:0] seg_of(input logic [7:0] c);
    logic [6:0] tab [0:9];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (c <= 8'd9) return tab[c];
    if (c == 8'hFF) return 7'h7F;
    return 7'h3F;
  endfunction

  function automatic logic [7:0] exp_anode(input int t, input int sel);
    logic [7:0] one;
    one = 8'd1;
    return (t > B) ? ~(one << sel) : 8'hFF;
  endfunction

  function automatic logic [6:0] exp_seg(input int t, input logic [7:0] c);
    return (t > B) ? seg_of(c) : 7'h7F;
  endfunction

  function automatic logic [7:0] rand_code();
    case ($urandom_range(0, 3))
      0, 1:    return 8'($urandom_range(0, 9));
      2:       return 8'hFF;
      default: return 8'($urandom_range(10, 254));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("anode", anode_n, exp_anode(m_t, m_sel));
      chk("seg", seg_n, exp_seg(m_t, m_code));
      chk("sel", digit_sel, m_sel);
      chk("dp", dp_n, 1);
      chk("one_lit", ($countones(~anode_n) <= 1), 1);
      chk("anode1", anode1, exp_anode(m1_t, m1_sel));
      chk("seg1", seg1, exp_seg(m1_t, m1_code));
      chk("sel1", sel1, m1_sel);
      case (mode)
        1: digit_code = rand_code();
        2: begin
          digit_code = rand_code();
          en = ($urandom_range(0, 9) != 0);
        end
        3: digit_code = src[digit_sel];
        default: ;
      endcase
    end
  endtask

  task automatic wait_show(input int sel);
    int n;
    n = 0;
    while (!(m_sel == sel && m_t > B) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("wait_show", (m_sel == sel && m_t > B), 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) src[i] = 8'($urandom_range(0, 9));
    src[1] = 8'hFF;
    src[2] = 8'h0C;

    // Held in reset, then a steady code 3 for two full frames
    cyc(3);
    rst_n = 1'b1;
    en = 1'b1;
    cyc(2 * N * P);

    // Code changes every cycle: only the value at the fetch cycle may show
    mode = 1;
    cyc(150);

    // Source indexed by position, including blank and invalid codes
    mode = 3;
    cyc(2 * N * P);

    // Enable dropped for 10 cycles while position 2 is lit
    mode = 1;
    wait_show(2);
    en = 1'b0;
    mode = 0;
    cyc(10);
    en = 1'b1;
    mode = 1;
    cyc(2 * P);

    // Random enable glitches
    mode = 2;
    cyc(300);
    en = 1'b1;
    mode = 1;

    // Asynchronous reset while position 3 is lit
    wait_show(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_anode", anode_n, 8'hFF);
    chk("rst_async_seg", seg_n, 7'h7F);
    chk("rst_async_sel", digit_sel, 0);
    chk("rst_async_anode1", anode1, 8'hFF);
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(3 * N * P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
